// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, HI/LO select
// codes, FSM states and default latencies.
package mul_div_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;

  // Shared by we (write select) and re (read select).
  localparam logic [1:0] MD_SEL_NONE = 2'b00;
  localparam logic [1:0] MD_SEL_LO   = 2'b01;
  localparam logic [1:0] MD_SEL_HI   = 2'b10;
  localparam logic [1:0] MD_SEL_BOTH = 2'b11;

  localparam int MD_MUL_LAT_DEF = 5;
  localparam int MD_DIV_LAT_DEF = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/mul_div_unit_md_compute.sv
// Combinational HI/LO result for one mult/multu/div/divu request; flags
// divide-by-zero so the caller can suppress the commit.
module md_compute
  import mul_div_unit_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_src_a,
  input  logic [31:0] i_src_b,
  output logic [31:0] o_pend_hi,
  output logic [31:0] o_pend_lo,
  output logic        o_div0,
  output logic        o_valid,
  output logic        o_is_div
);

  logic [63:0] w_smul;
  logic [63:0] w_umul;
  logic        w_b_zero;
  logic        w_sovf;
  logic [31:0] w_sb_safe;
  logic [31:0] w_ub_safe;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_uq;
  logic [31:0] w_ur;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign w_smul = {{32{i_src_a[31]}}, i_src_a} * {{32{i_src_b[31]}}, i_src_b};
  assign w_umul = {32'd0, i_src_a} * {32'd0, i_src_b};

  assign w_b_zero = (i_src_b == 32'd0);
  assign w_sovf   = (i_src_a == 32'h8000_0000) && (i_src_b == 32'hFFFF_FFFF);

  // Divisors are steered away from 0 and the overflow pair so the dividers never see them.
  assign w_sb_safe = (w_b_zero || w_sovf) ? 32'd1 : i_src_b;
  assign w_ub_safe = w_b_zero ? 32'd1 : i_src_b;

  assign w_sq = $signed(i_src_a) / $signed(w_sb_safe);
  assign w_sr = $signed(i_src_a) % $signed(w_sb_safe);
  assign w_uq = i_src_a / w_ub_safe;
  assign w_ur = i_src_a % w_ub_safe;

  always_comb begin
    o_pend_hi = 32'd0;
    o_pend_lo = 32'd0;
    o_div0    = 1'b0;
    o_valid   = 1'b0;
    o_is_div  = 1'b0;
    case (i_op)
      MD_MULT: begin
        o_valid   = 1'b1;
        o_pend_hi = w_smul[63:32];
        o_pend_lo = w_smul[31:0];
      end
      MD_MULTU: begin
        o_valid   = 1'b1;
        o_pend_hi = w_umul[63:32];
        o_pend_lo = w_umul[31:0];
      end
      MD_DIV: begin
        o_valid  = 1'b1;
        o_is_div = 1'b1;
        o_div0   = w_b_zero;
        if (w_sovf) begin
          o_pend_hi = 32'd0;
          o_pend_lo = 32'h8000_0000;
        end else begin
          o_pend_hi = w_sr;
          o_pend_lo = w_sq;
        end
      end
      MD_DIVU: begin
        o_valid   = 1'b1;
        o_is_div  = 1'b1;
        o_div0    = w_b_zero;
        o_pend_hi = w_ur;
        o_pend_lo = w_uq;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multiply/divide responder for the EX stage: owns HI/LO, runs fixed-latency
// operations and services mthi/mtlo/mfhi/mflo.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MUL_LAT = MD_MUL_LAT_DEF,
  parameter int DIV_LAT = MD_DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [1:0]  we,
  input  logic [1:0]  re,
  output logic [31:0] rd,
  output logic        busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  md_state_e   r_state;
  md_state_e   w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic [31:0] r_hi;
  logic [31:0] w_hi_next;
  logic [31:0] r_lo;
  logic [31:0] w_lo_next;
  logic [31:0] r_pend_hi;
  logic [31:0] w_pend_hi_next;
  logic [31:0] r_pend_lo;
  logic [31:0] w_pend_lo_next;
  logic        r_pend_div0;
  logic        w_pend_div0_next;

  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_div0;
  logic        w_op_valid;
  logic        w_is_div;

  md_compute u_md_compute (
    .i_op      (op),
    .i_src_a   (src_a),
    .i_src_b   (src_b),
    .o_pend_hi (w_res_hi),
    .o_pend_lo (w_res_lo),
    .o_div0    (w_div0),
    .o_valid   (w_op_valid),
    .o_is_div  (w_is_div)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_pend_hi   <= 32'd0;
      r_pend_lo   <= 32'd0;
      r_pend_div0 <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_hi        <= w_hi_next;
      r_lo        <= w_lo_next;
      r_pend_hi   <= w_pend_hi_next;
      r_pend_lo   <= w_pend_lo_next;
      r_pend_div0 <= w_pend_div0_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_count_next     = r_count;
    w_hi_next        = r_hi;
    w_lo_next        = r_lo;
    w_pend_hi_next   = r_pend_hi;
    w_pend_lo_next   = r_pend_lo;
    w_pend_div0_next = r_pend_div0;
    case (r_state)
      IDLE: begin
        // start wins over we in the same cycle, even for an ignored op code.
        if (start) begin
          if (w_op_valid) begin
            w_pend_hi_next   = w_res_hi;
            w_pend_lo_next   = w_res_lo;
            w_pend_div0_next = w_div0;
            w_count_next     = w_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
            w_state_next     = RUN;
          end
        end else if (we == MD_SEL_LO) begin
          w_lo_next = src_a;
        end else if (we == MD_SEL_HI) begin
          w_hi_next = src_a;
        end
      end
      RUN: begin
        if (r_count == CNT_W'(1)) begin
          if (!r_pend_div0) begin
            w_hi_next = r_pend_hi;
            w_lo_next = r_pend_lo;
          end
          w_count_next = '0;
          w_state_next = IDLE;
        end else begin
          w_count_next = r_count - CNT_W'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign busy = (r_state == RUN);

  always_comb begin
    rd = 32'd0;
    if (re == MD_SEL_LO) begin
      rd = r_lo;
    end else if (re == MD_SEL_HI) begin
      rd = r_hi;
    end
  end

  // Protocol checks: the hazard unit should never let these through.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_start_in_run : assert (!(start && r_state == RUN))
        else $warning("mul_div_unit: start during RUN ignored");
      a_we_dropped : assert (!((we == MD_SEL_LO || we == MD_SEL_HI) && (start || r_state == RUN)))
        else $warning("mul_div_unit: HI/LO write dropped (start or RUN)");
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized checks of mul_div_unit against a plain-arithmetic
// HI/LO reference model.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [1:0]  we;
  logic [1:0]  re;
  logic [31:0] rd;
  logic        busy;

  int ncmp = 0;
  int nerr = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mul_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .we    (we),
    .re    (re),
    .rd    (rd),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    re = MD_SEL_HI; #1;
    check({tag, "_hi"}, rd, m_hi);
    re = MD_SEL_LO; #1;
    check({tag, "_lo"}, rd, m_lo);
    re = MD_SEL_BOTH; #1;
    check({tag, "_re11"}, rd, 32'd0);
    re = MD_SEL_NONE;
  endtask

  task automatic check_const(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    re = MD_SEL_HI; #1;
    check({tag, "_hi_const"}, rd, hi);
    re = MD_SEL_LO; #1;
    check({tag, "_lo_const"}, rd, lo);
    re = MD_SEL_NONE;
  endtask

  // Reference: HI/LO from 64-bit arithmetic; divide by zero leaves HI/LO alone.
  function automatic void model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    longint unsigned up;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      MD_MULT: begin
        p = sa * sb;
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      MD_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      MD_DIV: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      MD_DIVU: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      default: ;
    endcase
  endfunction

  // Launch one op, optionally pulse start again at busy cycle `inject`.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] w, input int inject, input int lat);
    int n = 0;
    @(negedge clk);
    op = o; src_a = a; src_b = b; we = w; start = 1'b1;
    model_op(o, a, b);
    @(negedge clk);
    start = 1'b0; we = MD_SEL_NONE;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == inject) begin
        start = 1'b1; op = MD_MULT; src_a = $urandom;
      end
      @(negedge clk);
      start = 1'b0;
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'(lat));
    check_regs(tag);
    $display("op %-12s code=%0d a=%08h b=%08h busy=%0d hi=%08h lo=%08h", tag, o, a, b, n, m_hi, m_lo);
  endtask

  task automatic write_reg(input string tag, input logic [1:0] w, input logic [31:0] d);
    @(negedge clk);
    we = w; src_a = d;
    if (w == MD_SEL_LO) m_lo = d;
    else if (w == MD_SEL_HI) m_hi = d;
    @(negedge clk);
    we = MD_SEL_NONE;
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check_regs(tag);
    $display("wr %-12s we=%b data=%08h hi=%08h lo=%08h", tag, w, d, m_hi, m_lo);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          sel;

    reset = 1'b1; start = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    we = MD_SEL_NONE; re = MD_SEL_NONE;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check_regs("reset");
    reset = 1'b0;

    run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, MD_SEL_NONE, -1, 5);
    check_const("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, MD_SEL_NONE, -1, 5);
    check_const("multu", 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, MD_SEL_NONE, -1, 10);
    check_const("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", MD_DIVU, 32'd7, 32'd2, MD_SEL_NONE, -1, 10);
    check_const("divu", 32'd1, 32'd3);

    write_reg("mtlo", MD_SEL_LO, 32'h1234_5678);
    run_op("div0", MD_DIV, 32'd5, 32'd0, MD_SEL_NONE, -1, 10);
    check_const("div0", 32'd1, 32'h1234_5678);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, MD_SEL_NONE, -1, 10);
    check_const("div_ovf", 32'd0, 32'h8000_0000);
    write_reg("mthi", MD_SEL_HI, 32'hAAAA_5555);
    write_reg("we11", MD_SEL_BOTH, 32'hDEAD_BEEF);

    // Reset during the third busy cycle of a mult aborts it.
    @(negedge clk);
    op = MD_MULT; src_a = 32'h0001_2345; src_b = 32'h0006_7890; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_mid_busy1", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check_regs("rst_mid");
    repeat (8) @(negedge clk);
    check("rst_late_busy", 32'(busy), 32'd0);
    check_regs("rst_late");
    $display("op %-12s reset at third busy cycle hi=%08h lo=%08h", "mult_abort", m_hi, m_lo);

    // Unused op code is ignored.
    @(negedge clk);
    op = 3'd5; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("badop_busy", 32'(busy), 32'd0);
    check_regs("badop");

    run_op("start_we", MD_MULTU, 32'd7, 32'd9, MD_SEL_LO, -1, 5);
    run_op("start_in_run", MD_DIV, 32'd100, 32'd7, MD_SEL_NONE, 3, 10);

    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom);
      if (sel <= 7) begin
        ro = 3'(sel % 4);
        run_op($sformatf("rnd%0d", i), ro, ra, rb, MD_SEL_NONE, -1, (ro >= MD_DIV) ? 10 : 5);
      end else begin
        write_reg($sformatf("rndwr%0d", i), (sel == 8) ? MD_SEL_LO : MD_SEL_HI, ra);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Responder side of the EX-stage multiply/divide handshake. The EX stage drives operands, operation code, start, write-enable and read-select, and consumes the read data and busy.
- Owns the HI/LO registers and executes mult/multu/div/divu with fixed multi-cycle latency.
- Services mthi/mtlo writes and mfhi/mflo reads.
- busy is exported so the hazard unit stalls MD instructions on (start | busy).

Parameters:
- MUL_LAT, 5, cycles busy is held for mult/multu
- DIV_LAT, 10, cycles busy is held for div/divu

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse launching the operation encoded on op
- op  input  3  0=mult, 1=multu, 2=div, 3=divu, others=no-op
- src_a  input  32  operand A (rs); also the mthi/mtlo write data
- src_b  input  32  operand B (rt)
- we  input  2  01=write LO (mtlo), 10=write HI (mthi), 00/11=none
- re  input  2  01=read LO (mflo), 10=read HI (mfhi), 00/11=read zero
- rd  output  32  read data, combinational from the HI/LO registers
- busy  output  1  high while an operation is in flight

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: HI=0, LO=0, busy=0, state=IDLE, count=0. rd follows re and therefore reads 0 after reset.
- FSM states:
  - IDLE:
    - start=1 with op in 0..3: latch the pending result, computed from src_a/src_b in that cycle, into PEND_HI/PEND_LO.
    - Load count with MUL_LAT or DIV_LAT, then go to RUN. busy rises in the next cycle.
  - RUN:
    - busy=1 and count decrements each cycle.
    - In the cycle count==1, HI/LO take PEND_HI/PEND_LO at the clock edge, the FSM returns to IDLE and busy falls.
- Timing: a start sampled at edge N gives busy=1 on cycles N+1..N+LAT. The new HI/LO are visible on rd from cycle N+LAT+1.
- Arithmetic:
  - mult: signed 64-bit product, HI=[63:32], LO=[31:0]. multu is the unsigned equivalent.
  - div: LO=quotient, HI=remainder, both truncated toward zero; the remainder takes the dividend's sign. divu is the unsigned equivalent.
- Divide by zero (div or divu with src_b=0): the operation still runs the full DIV_LAT with busy high. HI/LO keep their previous values.
- Signed overflow (div 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- start with op in 4..7: ignored; the FSM stays in IDLE and busy stays 0.
- start while in RUN is a protocol violation because the hazard unit prevents it. It is ignored, and a simulation-only assertion fires.
- we in IDLE with start=0: the selected register takes src_a at the edge.
- we while in RUN, or in the same cycle as start: the write is dropped; start has priority. A simulation assertion flags it.
- we=11: no write.
- rd is never affected by busy. A read during RUN returns the old HI/LO, which the stall logic prevents in practice.
- Reset during RUN: the operation is aborted. HI/LO go to 0, PEND is discarded and busy=0 on the next cycle.

Decomposition:
- Shared package holds:
  - the op encoding constants MD_MULT, MD_MULTU, MD_DIV, MD_DIVU
  - the we/re select encodings
  - the state encodings IDLE and RUN
  - the default latency constants
- One sub-module is natural: md_compute. It is combinational: op, src_a, src_b -> pend_hi, pend_lo, div0 flag, with the signed/unsigned and divide-by-zero rules above.
- The FSM, counter and HI/LO registers stay in the top module.

Test Plan:
- Reset, then mult 0xFFFFFFFE × 3 -> busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div 0xFFFFFFF9 (-7) / 2 -> busy high for exactly 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7 / 2 -> LO=3, HI=1.
- mtlo 0x12345678, then div 5 / 0 -> busy still high for 10 cycles. Afterwards LO=0x12345678 and HI is unchanged.
- div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. Then mthi 0xAAAA5555 in IDLE -> rd with re=10 returns 0xAAAA5555 on the next cycle.
- Assert reset at the third busy cycle of a mult -> next cycle busy=0, HI=LO=0, and no late commit of the pending result.
- start together with we=01 in the same cycle -> the LO write is dropped and the operation result commits. A start pulse during RUN -> no restart, and busy falls on schedule.
